firebird7_in_gate1_tessent_tdr_mux_ctrl_w3: RTL and testbench
=============================================================

# firebird7_in_gate1_tessent_tdr_mux_ctrl_w3

IJTAG test data register (TDR) that sits at the other end of the gate1 3-bit IJTAG data mux. It shifts a control word in from the IJTAG network and, on update, drives the mux select and override data. On capture, it returns the mux output and a sticky override-mismatch flag to the network. One instance pairs with one mux instance inside the gate1 IJTAG instrument.

## Interface
Parameters:
- WIDTH, 3, width of the override data and of the observed mux output.

Ports:
- ijtag_tck  in  1  TCK; the only clock; all flops on the rising edge.
- ijtag_reset  in  1  asynchronous, active-low reset.
- ijtag_sel  in  1  segment selected on the IJTAG scan path; qualifies ce/se/ue.
- ijtag_ce  in  1  capture enable.
- ijtag_se  in  1  shift enable.
- ijtag_ue  in  1  update enable.
- ijtag_si  in  1  scan in.
- ijtag_so  out  1  scan out; equals shift register bit 0.
- mux_data_out  in  WIDTH  mux output, observed for capture and compare.
- ijtag_select  out  1  drives the mux select; registered.
- ijtag_data_out  out  WIDTH  drives the mux override data; registered.

## Operation
- Shift register SR has LEN = WIDTH+2 bits:
  - SR[0] = SEL field.
  - SR[WIDTH:1] = DATA field.
  - SR[WIDTH+1] = CLR on update, STICKY on capture.
- Operation select: ijtag_sel must be 1 for any operation. Priority is ce > se > ue. With ijtag_sel=0, SR and the update registers hold.
- Capture: SR <= {sticky_q, mux_data_out, select_q}.
- Shift: SR <= {ijtag_si, SR[LEN-1:1]}, LSB first out. ijtag_so = SR[0] at all times, including when not selected.
- Update:
  - select_q <= SR[0].
  - data_q <= SR[WIDTH:1].
  - If SR[WIDTH+1]=1, sticky_q <= 0.
  - SR is unchanged.
- Outputs: ijtag_select = select_q; ijtag_data_out = data_q.
- Compare: each tck with select_q=1 and mux_data_out != data_q, sticky_q <= 1. No compare when select_q=0.
- Update with CLR=1 in the same cycle as a mismatch: the clear wins. That compare uses the values being replaced.
- No state machine beyond ce/se/ue decode. Operations are single-cycle.

## Timing
- Reset values (async assert, sync-free release): SR=0, select_q=0, data_q=0, sticky_q=0, so ijtag_so=0, ijtag_select=0, ijtag_data_out=0.
- Update latency: ijtag_select and ijtag_data_out change on the tck edge where ue is sampled, visible 1 cycle after ue is asserted.
- Capture latency: capture samples mux_data_out at the ce edge. The first captured bit appears on ijtag_so immediately after that edge.
- Shift output: the first shifted-out bit is SR[0] from before the first se edge. A full LEN-cycle shift replaces the whole SR.
- Sticky: set 1 cycle after the mismatching sample. Visible to capture on the next ce edge, not the same one.
- Reset asserted mid-shift or mid-override: all state clears immediately. The mux returns to functional path (ijtag_select=0) combinationally via the flop reset.
- Simultaneous ce/se/ue: only the highest-priority operation acts. No error is flagged.

## Structure
- Shared package firebird7_in_gate1_tessent_tdr_pkg holds:
  - field offset constants SEL_POS=0, DATA_LSB=1, CLR_POS.
  - function tdr_len(width) = width+2.
- Single module, no sub-module. The compare is inline.
- The bench instantiates the existing 3-bit data mux between ijtag_select/ijtag_data_out and mux_data_out. Functional data comes from a bench driver.

## Test plan
- Reset then capture with functional=3'b101, no override → shifted-out word LSB-first = SEL 0, DATA 101, STICKY 0.
- Shift in SEL=1, DATA=3'b110, CLR=0, then update → ijtag_select=1 and ijtag_data_out=3'b110 one cycle later; capture returns DATA 110, STICKY 0.
- With override active, force mux_data_out to 3'b010 for 1 cycle (bench bypasses mux) → sticky_q=1; next capture returns STICKY 1; the flag persists after the forcing is removed.
- Update with CLR=1 in the same cycle as a forced mismatch → sticky_q=0 after the edge.
- Assert ce, se and ue together with ijtag_sel=1 → only capture occurs; update registers unchanged. Repeat with ijtag_sel=0 → nothing changes, and ijtag_so holds SR[0].
- Drop ijtag_reset midway through a 5-bit shift with override active → all outputs 0 immediately; the mux passes functional data.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared definitions for the gate1 IJTAG mux-control TDR.
// Field offsets within the shift register and operation decode.
package firebird7_in_gate1_tessent_tdr_pkg;

  localparam int TDR_WIDTH = 3;
  localparam int SEL_POS   = 0;
  localparam int DATA_LSB  = 1;
  localparam int CLR_POS   = TDR_WIDTH + 1;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_CAP,
    OP_SHF,
    OP_UPD
  } tdr_op_e;

  function automatic int tdr_len(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_mux_ctrl_w3.sv
// IJTAG TDR driving the gate1 data mux select/override data.
// Captures the mux output plus a sticky override-mismatch flag.
module firebird7_in_gate1_tessent_tdr_mux_ctrl_w3
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] mux_data_out,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out
);

  localparam int LEN   = tdr_len(WIDTH);
  localparam int CLR_B = LEN - 1;

  logic [LEN-1:0]   r_sr;
  logic             r_sel;
  logic [WIDTH-1:0] r_data;
  logic             r_sticky;

  tdr_op_e w_op;
  logic    w_mismatch;
  logic    w_clr;

  // Capture outranks shift, shift outranks update.
  always_comb begin
    w_op = OP_NONE;
    if (ijtag_sel) begin
      if (ijtag_ce)      w_op = OP_CAP;
      else if (ijtag_se) w_op = OP_SHF;
      else if (ijtag_ue) w_op = OP_UPD;
    end
  end

  assign w_mismatch = r_sel && (mux_data_out != r_data);
  assign w_clr      = (w_op == OP_UPD) && r_sr[CLR_B];

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_sr <= '0;
    end else begin
      case (w_op)
        OP_CAP:  r_sr <= {r_sticky, mux_data_out, r_sel};
        OP_SHF:  r_sr <= {ijtag_si, r_sr[LEN-1:1]};
        default: r_sr <= r_sr;
      endcase
    end
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_sel  <= 1'b0;
      r_data <= '0;
    end else if (w_op == OP_UPD) begin
      r_sel  <= r_sr[SEL_POS];
      r_data <= r_sr[WIDTH:DATA_LSB];
    end
  end

  // Clear beats a same-cycle mismatch against the outgoing values.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_sticky <= 1'b0;
    end else if (w_clr) begin
      r_sticky <= 1'b0;
    end else if (w_mismatch) begin
      r_sticky <= 1'b1;
    end
  end

  assign ijtag_so       = r_sr[0];
  assign ijtag_select   = r_sel;
  assign ijtag_data_out = r_data;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_mux_ctrl_w3.sv
// Directed bench for the gate1 mux-control TDR with a behavioural
// 3-bit data mux between the TDR outputs and mux_data_out.
module tb_firebird7_in_gate1_tessent_tdr_mux_ctrl_w3;

  logic       tck = 1'b0;
  logic       rst_n;
  logic       sel, ce, se, ue, si;
  logic       so;
  logic       msel;
  logic [2:0] mdata;
  logic [2:0] mux_out;
  logic [2:0] func;
  logic       force_en;
  logic [2:0] force_val;

  int total = 0;
  int bad   = 0;

  always #5 tck = ~tck;

  assign mux_out = force_en ? force_val : (msel ? mdata : func);

  firebird7_in_gate1_tessent_tdr_mux_ctrl_w3 #(.WIDTH(3)) dut (
    .ijtag_tck      (tck),
    .ijtag_reset    (rst_n),
    .ijtag_sel      (sel),
    .ijtag_ce       (ce),
    .ijtag_se       (se),
    .ijtag_ue       (ue),
    .ijtag_si       (si),
    .ijtag_so       (so),
    .mux_data_out   (mux_out),
    .ijtag_select   (msel),
    .ijtag_data_out (mdata)
  );

  typedef struct {
    logic       ce, se, ue, si;
    logic [2:0] func;
    logic       so, msel;
    logic [2:0] mdata;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic c, s, u, i,
                              input logic [2:0] f,
                              input logic eso, esel,
                              input logic [2:0] ed);
    vec_t v;
    v.ce = c; v.se = s; v.ue = u; v.si = i; v.func = f;
    v.so = eso; v.msel = esel; v.mdata = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic idle();
    ce = 0; se = 0; ue = 0; si = 0;
  endtask

  task automatic shift_in(input logic [4:0] w);
    for (int i = 0; i < 5; i++) begin
      sel = 1; ce = 0; se = 1; ue = 0; si = w[i];
      tick();
    end
    idle();
  endtask

  task automatic shift_read4(output logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      sel = 1; ce = 0; se = 1; ue = 0; si = 0;
      tick();
      r[i] = so;
    end
    idle();
  endtask

  task automatic capture_read(input logic fen, input logic [2:0] fv,
                              output logic [4:0] w);
    logic [3:0] r;
    sel = 1; ce = 1; se = 0; ue = 0; si = 0;
    force_en = fen; force_val = fv;
    tick();
    w[0] = so;
    force_en = 0;
    idle();
    shift_read4(r);
    w[4:1] = r;
  endtask

  logic [4:0] w;
  logic [3:0] r4;

  initial begin
    rst_n = 0; sel = 0; idle();
    func = 3'b101; force_en = 0; force_val = 0;

    tbl[0]  = mk(1,0,0,0,3'b101, 0,0,3'b000);
    tbl[1]  = mk(0,1,0,0,3'b101, 1,0,3'b000);
    tbl[2]  = mk(0,1,0,0,3'b101, 0,0,3'b000);
    tbl[3]  = mk(0,1,0,0,3'b101, 1,0,3'b000);
    tbl[4]  = mk(0,1,0,0,3'b101, 0,0,3'b000);
    tbl[5]  = mk(0,1,0,1,3'b101, 0,0,3'b000);
    tbl[6]  = mk(0,1,0,0,3'b101, 0,0,3'b000);
    tbl[7]  = mk(0,1,0,1,3'b101, 0,0,3'b000);
    tbl[8]  = mk(0,1,0,1,3'b101, 0,0,3'b000);
    tbl[9]  = mk(0,1,0,0,3'b101, 1,0,3'b000);
    tbl[10] = mk(0,0,1,0,3'b101, 1,1,3'b110);
    tbl[11] = mk(1,0,0,0,3'b101, 1,1,3'b110);
    tbl[12] = mk(0,1,0,0,3'b101, 0,1,3'b110);
    tbl[13] = mk(0,1,0,0,3'b101, 1,1,3'b110);
    tbl[14] = mk(0,1,0,0,3'b101, 1,1,3'b110);
    tbl[15] = mk(0,1,0,0,3'b101, 0,1,3'b110);

    tick(); tick();
    check("rst_so", so, 0);
    check("rst_select", msel, 0);
    check("rst_data", mdata, 0);
    rst_n = 1;
    tick();

    // Capture functional word, shift in override, update, read back
    for (int i = 0; i < 16; i++) begin
      sel = 1;
      ce = tbl[i].ce; se = tbl[i].se; ue = tbl[i].ue; si = tbl[i].si;
      func = tbl[i].func;
      tick();
      check($sformatf("vec%0d_so", i), so, tbl[i].so);
      check($sformatf("vec%0d_select", i), msel, tbl[i].msel);
      check($sformatf("vec%0d_data", i), mdata, tbl[i].mdata);
    end
    idle();

    // Forced mismatch on the capture edge: sticky not yet visible
    capture_read(1, 3'b010, w);
    check("cap_same_edge", w, 5'b00101);
    capture_read(0, 3'b000, w);
    check("cap_sticky_set", w, 5'b11101);
    tick(); tick(); tick();
    capture_read(0, 3'b000, w);
    check("cap_sticky_persist", w, 5'b11101);

    // Update with CLR while a mismatch is forced
    shift_in(5'b11101);
    sel = 1; ue = 1; force_en = 1; force_val = 3'b010;
    tick();
    force_en = 0; idle();
    check("clr_select", msel, 1);
    check("clr_data", mdata, 3'b110);
    capture_read(0, 3'b000, w);
    check("clr_sticky", w, 5'b01101);

    // ce/se/ue together: capture only
    shift_in(5'b00100);
    func = 3'b011;
    sel = 1; ce = 1; se = 1; ue = 1; si = 0;
    tick();
    check("all_so", so, 1);
    check("all_select", msel, 1);
    check("all_data", mdata, 3'b110);
    idle();
    shift_read4(r4);
    check("all_word", r4, 4'b0110);

    // Same with segment deselected: nothing moves
    shift_in(5'b00111);
    check("desel_pre_so", so, 1);
    sel = 0; ce = 1; se = 1; ue = 1; si = 0;
    tick(); tick(); tick();
    check("desel_so", so, 1);
    check("desel_select", msel, 1);
    check("desel_data", mdata, 3'b110);
    idle();
    shift_read4(r4);
    check("desel_word", r4, 4'b0011);

    // Reset dropped mid-shift with override active
    func = 3'b101;
    sel = 1; se = 1; si = 1;
    tick(); tick();
    #3;
    rst_n = 0;
    #1;
    check("mrst_so", so, 0);
    check("mrst_select", msel, 0);
    check("mrst_data", mdata, 0);
    check("mrst_mux", mux_out, 3'b101);
    idle();
    @(negedge tck);
    rst_n = 1;
    tick();
    check("post_rst_select", msel, 0);
    check("post_rst_so", so, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
